// File: rtl/brick_pkg.sv
// Shared types and constants for the brick collision path: scan FSM states,
// the brick record as stored in brick_memory, and the ball snapshot record.
package brick_pkg;

    localparam int NUM_BRICKS = 40;
    localparam int IDX_W      = 6;
    localparam int COORD_W    = 8;
    localparam int DIM_W      = 4;
    localparam int VEL_W      = 3;

    // Geometry sums are formed one bit wider than the 9-bit coordinate sums
    // so that far-edge values such as 255+3 or 255+15 keep their true value
    // and a negative next position never aliases onto a large coordinate.
    localparam int CMP_W = COORD_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE,
        ST_DONE
    } scan_state_e;

    // One brick slot, identical to the brick_memory word layout.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [DIM_W-1:0]   w;
        logic [DIM_W-1:0]   h;
        logic               active;
    } brick_t;

    // Ball position and velocity frozen for the duration of one scan.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [VEL_W-1:0]   vx;
        logic [VEL_W-1:0]   vy;
    } ball_snap_t;

    // Unsigned coordinate into the signed compare domain.
    function automatic logic signed [CMP_W-1:0] to_cmp_coord(input logic [COORD_W-1:0] v);
        return signed'(CMP_W'(v));
    endfunction

    // Unsigned brick dimension into the signed compare domain.
    function automatic logic signed [CMP_W-1:0] to_cmp_dim(input logic [DIM_W-1:0] v);
        return signed'(CMP_W'(v));
    endfunction

    // Two's complement velocity, sign-extended into the compare domain.
    function automatic logic signed [CMP_W-1:0] to_cmp_vel(input logic [VEL_W-1:0] v);
        return CMP_W'(signed'(v));
    endfunction

endpackage

// File: rtl/brick_scan_ctrl_if.sv
// brick_memory port bundle: the scan controller is the master that drives the
// address and write strobe, the memory is the slave returning the brick word
// one cycle after the address.
interface brick_scan_ctrl_if #(
    parameter int IDX_W = brick_pkg::IDX_W
);
    logic [IDX_W-1:0] mem_addr;
    logic             mem_we;
    logic [7:0]       mem_brickX;
    logic [7:0]       mem_brickY;
    logic [3:0]       mem_brickW;
    logic [3:0]       mem_brickH;
    logic             mem_active;

    modport master (
        output mem_addr,
        output mem_we,
        input  mem_brickX,
        input  mem_brickY,
        input  mem_brickW,
        input  mem_brickH,
        input  mem_active
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        output mem_brickX,
        output mem_brickY,
        output mem_brickW,
        output mem_brickH,
        output mem_active
    );
endinterface

// File: rtl/brick_hit_test.sv
// Combinational overlap test of one brick against a ball snapshot.
// A y-axis (top/bottom) hit takes priority; an x-axis (side) hit is only
// reported when there is no y-axis hit. Inactive bricks never hit.
module brick_hit_test
    import brick_pkg::*;
(
    input  ball_snap_t i_ball,
    input  brick_t     i_brick,
    output logic       o_hitX,
    output logic       o_hitY
);

    logic signed [CMP_W-1:0] w_ball_x;
    logic signed [CMP_W-1:0] w_ball_y;
    logic signed [CMP_W-1:0] w_next_x;
    logic signed [CMP_W-1:0] w_next_y;
    logic signed [CMP_W-1:0] w_left;
    logic signed [CMP_W-1:0] w_top;
    logic signed [CMP_W-1:0] w_right;
    logic signed [CMP_W-1:0] w_bottom;
    logic                    w_y_hit;
    logic                    w_x_hit;

    assign w_ball_x = to_cmp_coord(i_ball.x);
    assign w_ball_y = to_cmp_coord(i_ball.y);
    assign w_next_x = w_ball_x + to_cmp_vel(i_ball.vx);
    assign w_next_y = w_ball_y + to_cmp_vel(i_ball.vy);

    assign w_left   = to_cmp_coord(i_brick.x);
    assign w_top    = to_cmp_coord(i_brick.y);
    assign w_right  = w_left + to_cmp_dim(i_brick.w);
    assign w_bottom = w_top  + to_cmp_dim(i_brick.h);

    // Ball column inside the brick and the next row entering it.
    assign w_y_hit = i_brick.active
                   && (w_left < w_ball_x) && (w_ball_x < w_right)
                   && (w_top  < w_next_y) && (w_next_y <= w_bottom);

    // Ball row inside the brick and the next column entering it.
    assign w_x_hit = i_brick.active
                   && (w_top  < w_ball_y) && (w_ball_y <= w_bottom)
                   && (w_left < w_next_x) && (w_next_x < w_right);

    assign o_hitY = w_y_hit;
    assign o_hitX = w_x_hit && !w_y_hit;

endmodule

// File: rtl/brick_scan_ctrl.sv
// Per-frame brick scan scheduler. On an accepted start it freezes the ball
// state, walks every brick slot (READ then CHECK per slot, one-cycle memory
// latency), clears the first brick hit with a single write-back, reports the
// collision axis and pulses done.
module brick_scan_ctrl #(
    parameter int NUM_BRICKS = brick_pkg::NUM_BRICKS,
    parameter int IDX_W      = brick_pkg::IDX_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              ballX,
    input  logic [7:0]              ballY,
    input  logic [2:0]              vX,
    input  logic [2:0]              vY,
    brick_scan_ctrl_if.master       mem,
    output logic                    busy,
    output logic                    done,
    output logic                    cBrickX,
    output logic                    cBrickY,
    output logic [IDX_W-1:0]        hit_index,
    output logic                    score_inc
);

    import brick_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICKS - 1);

    scan_state_e      r_state;
    scan_state_e      w_state_nxt;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_hit_index;
    ball_snap_t       r_snap;
    logic             r_cbrick_x;
    logic             r_cbrick_y;

    brick_t           w_brick;
    logic             w_hit_x;
    logic             w_hit_y;
    logic             w_any_hit;
    logic [IDX_W-1:0] w_mem_addr;
    logic             w_mem_we;
    logic             w_done;

    assign w_brick = '{
        x:      mem.mem_brickX,
        y:      mem.mem_brickY,
        w:      mem.mem_brickW,
        h:      mem.mem_brickH,
        active: mem.mem_active
    };

    brick_hit_test u_hit_test (
        .i_ball  (r_snap),
        .i_brick (w_brick),
        .o_hitX  (w_hit_x),
        .o_hitY  (w_hit_y)
    );

    assign w_any_hit = w_hit_x || w_hit_y;

    // State register; reset returns to IDLE and abandons any scan in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state memory/handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_mem_addr  = r_index;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                // Address is held so the memory word stays stable while tested.
                w_mem_addr = r_index;
                if (w_any_hit) begin
                    w_state_nxt = ST_WRITE;
                end else if (r_index == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                w_mem_addr  = r_hit_index;
                w_mem_we    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Scan datapath: ball snapshot, slot index, hit index and collision flags.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every register samples pre-edge values regardless of block order.
        if (!reset) begin
            r_index     <= '0;
            r_hit_index <= '0;
            r_snap      <= '0;
            r_cbrick_x  <= 1'b0;
            r_cbrick_y  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap     <= '{x: ballX, y: ballY, vx: vX, vy: vY};
                        r_index    <= '0;
                        r_cbrick_x <= 1'b0;
                        r_cbrick_y <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_any_hit) begin
                        r_hit_index <= r_index;
                        r_cbrick_x  <= w_hit_x;
                        r_cbrick_y  <= w_hit_y;
                    end else if (r_index != LAST_IDX) begin
                        r_index <= r_index + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.mem_addr = w_mem_addr;
    assign mem.mem_we   = w_mem_we;
    assign busy         = (r_state != ST_IDLE);
    assign done         = w_done;
    assign score_inc    = w_mem_we;
    assign cBrickX      = r_cbrick_x;
    assign cBrickY      = r_cbrick_y;
    assign hit_index    = r_hit_index;

endmodule
